run_detector: RTL

- Parametrised successor to the lab's fixed 5-state "two consecutive equal inputs" detector (states A..E).
- Detects runs of RUN_LEN consecutive equal samples of w, with per-polarity enables, level/pulse output mode and a saturating hit counter.
- Exposes both the binary and one-hot state encodings so board LEDs can show either, as the earlier lab top did.
- Sits between a switch/button input stage and the LED/display layer.

---
 rtl/run_detector_pkg.sv | 30 +++
 rtl/run_detector_sat_counter.sv | 38 +++
 rtl/run_detector.sv | 115 +++++++++++
 3 files changed

// File: rtl/run_detector_pkg.sv
// Shared definitions for the run detector: state numbering helpers and clog2.
package run_det_pkg;

  // Idle state index (the classic "A" state).
  localparam int S_IDLE = 0;

  // State index for "k consecutive 0s seen".
  function automatic int zero_state(input int k);
    return k;
  endfunction

  // State index for "k consecutive 1s seen"; ones states follow the zeros states.
  function automatic int one_state(input int k, input int run_len);
    return run_len + k;
  endfunction

  // Ceiling log2, used to size the binary state code.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/run_detector_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             R,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear first, then increment unless already at the top value.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge Clk) begin
    if (R) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/run_detector.sv
// Detects runs of RUN_LEN equal samples of w. State 0 is idle, 1..RUN_LEN
// count zeros, RUN_LEN+1..2*RUN_LEN count ones; the terminal states saturate.
module run_detector
  import run_det_pkg::*;
#(
  parameter  int RUN_LEN = 2,
  parameter  int CNT_W   = 8,
  localparam int NS      = 2 * RUN_LEN + 1,
  localparam int SW      = clog2(NS)
) (
  input  logic             Clk,
  input  logic             R,
  input  logic             w,
  input  logic             en,
  input  logic             det_zero,
  input  logic             det_one,
  input  logic             pulse_mode,
  input  logic             clr_cnt,
  output logic             Z,
  output logic [SW-1:0]    Y_out,
  output logic [NS-1:0]    state_oh,
  output logic [CNT_W-1:0] hit_cnt
);

  localparam logic [SW-1:0] ST_IDLE = SW'(S_IDLE);
  localparam logic [SW-1:0] Z_FIRST = SW'(zero_state(1));
  localparam logic [SW-1:0] Z_LAST  = SW'(zero_state(RUN_LEN));
  localparam logic [SW-1:0] O_FIRST = SW'(one_state(1, RUN_LEN));
  localparam logic [SW-1:0] O_LAST  = SW'(one_state(RUN_LEN, RUN_LEN));

  logic [SW-1:0] state_q;
  logic [SW-1:0] state_d;
  logic          entry_q;
  logic          entry_d;
  logic          in_zero_s;
  logic          in_one_s;
  logic          enter_s;
  logic          hit_inc_s;
  logic          level_s;
  logic [NS-1:0] state_oh_s;

  assign in_zero_s = (state_q >= Z_FIRST) && (state_q <= Z_LAST);
  assign in_one_s  = (state_q >= O_FIRST) && (state_q <= O_LAST);

  // Next state: extend the current run (saturating) or start a new one.
  always_comb begin
    state_d = state_q;
    if (en) begin
      if (w == 1'b0) begin
        if (in_zero_s && (state_q != Z_LAST)) begin
          state_d = state_q + SW'(1);
        end else if (in_zero_s) begin
          state_d = Z_LAST;
        end else begin
          state_d = Z_FIRST;
        end
      end else begin
        if (in_one_s && (state_q != O_LAST)) begin
          state_d = state_q + SW'(1);
        end else if (in_one_s) begin
          state_d = O_LAST;
        end else begin
          state_d = O_FIRST;
        end
      end
    end else begin
      state_d = state_q;
    end
  end

  // Entry into a terminal state from a different state marks a completed run.
  assign enter_s   = en && (state_d != state_q) &&
                     ((state_d == Z_LAST) || (state_d == O_LAST));
  assign hit_inc_s = enter_s && (((state_d == Z_LAST) && det_zero) ||
                                 ((state_d == O_LAST) && det_one));
  assign entry_d   = en ? enter_s : entry_q;

  // State and entry-flag registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (R) begin
      state_q <= ST_IDLE;
      entry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
    end
  end

  // Moore detection output; pulse mode keeps only the entry cycle.
  assign level_s = ((state_q == Z_LAST) && det_zero) ||
                   ((state_q == O_LAST) && det_one);
  assign Z       = pulse_mode ? (level_s && entry_q && en) : level_s;

  // Binary-to-one-hot decode of the state code for the LED layer.
  always_comb begin
    state_oh_s = '0;
    for (int i = 0; i < NS; i++) begin
      state_oh_s[i] = (state_q == SW'(i));
    end
  end

  assign state_oh = state_oh_s;
  assign Y_out    = state_q;

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_hit_cnt (
    .Clk   (Clk),
    .R     (R),
    .clr   (clr_cnt),
    .inc   (hit_inc_s),
    .count (hit_cnt)
  );

endmodule
